// File: rtl/fpu_cvt_pkg.sv
// Shared types for the INT->F32 converter result path.
// Status flag bundle and F32 field widths.
package fpu_cvt_pkg;

    localparam int F32_MANT_W = 23;

    typedef struct packed {
        logic inexact;
        logic negative;
        logic zero;
    } fpu_cvt_flags_t;

endpackage

// File: rtl/fpu_cvt_inexact_chk.sv
// Derives IEEE status flags for an INT32->F32 conversion from the source.
// Ports: src (signed INT32 operand) -> flags {inexact, negative, zero}.
module fpu_cvt_inexact_chk
    import fpu_cvt_pkg::*;
(
    input  logic [31:0]    src,
    output fpu_cvt_flags_t flags
);

    logic [31:0] mag;
    logic [31:0] mask;
    logic [4:0]  msb;
    logic [4:0]  sh;

    always_comb begin
        // 0x80000000 negates to itself, which read unsigned is 2^31.
        mag = src[31] ? (~src + 32'd1) : src;

        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                msb = i[4:0];
            end
        end

        // Bits below msb-23 fall off the 24-bit significand.
        sh   = msb - 5'(F32_MANT_W);
        mask = (32'd1 << sh) - 32'd1;

        flags.zero     = (src == 32'd0);
        flags.negative = src[31];
        flags.inexact  = (msb > 5'(F32_MANT_W)) && ((mag & mask) != 32'd0);
    end

endmodule

// File: rtl/fpu_cvt_result_queue.sv
// Result FIFO between the INT->F32 converter and FPU writeback.
// Ports: CLK/nRST/FLUSH, IN_* push side (registered IN_READY),
// OUT_* pop side with head tag/data/flags, LEVEL occupancy.
module fpu_cvt_result_queue
    import fpu_cvt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       FLUSH,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [TAG_W-1:0]           IN_TAG,
    input  logic [31:0]                IN_SRC,
    input  logic [31:0]                IN_RESULT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [TAG_W-1:0]           OUT_TAG,
    output logic [31:0]                OUT_DATA,
    output logic [2:0]                 OUT_FLAGS,
    output logic [$clog2(DEPTH):0]     LEVEL
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        fpu_cvt_flags_t   flags;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic             in_ready_q;
    logic             push;
    logic             pop;
    fpu_cvt_flags_t   in_flags;

    fpu_cvt_inexact_chk u_chk (
        .src   (IN_SRC),
        .flags (in_flags)
    );

    always_comb begin
        push      = IN_VALID && in_ready_q;
        pop       = (level != '0) && OUT_READY;
        level_nxt = level;
        if (FLUSH) begin
            level_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_nxt = level + LVL_W'(1);
                2'b01:   level_nxt = level - LVL_W'(1);
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            // Registered ready: a pop at full frees space one cycle later.
            in_ready_q <= (level_nxt < LVL_W'(DEPTH));
            if (FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= '{tag: IN_TAG, data: IN_RESULT, flags: in_flags};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (level != '0);
    assign OUT_TAG   = head.tag;
    assign OUT_DATA  = head.data;
    assign OUT_FLAGS = head.flags;
    assign LEVEL     = level;

endmodule

// File: tb/tb_fpu_cvt_result_queue.sv
// Directed bench for fpu_cvt_result_queue.
// Inputs change and outputs are checked on the falling edge.
module tb_fpu_cvt_result_queue;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [4:0]  IN_TAG;
    logic [31:0] IN_SRC;
    logic [31:0] IN_RESULT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [4:0]  OUT_TAG;
    logic [31:0] OUT_DATA;
    logic [2:0]  OUT_FLAGS;
    logic [2:0]  LEVEL;

    int tests = 0;
    int fails = 0;

    logic [4:0]  e_tag [4];
    logic [31:0] e_src [4];
    logic [31:0] e_res [4];
    logic [2:0]  e_flg [4];

    always #5 CLK = ~CLK;

    fpu_cvt_result_queue #(.DEPTH(4), .TAG_W(5)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_TAG    (IN_TAG),
        .IN_SRC    (IN_SRC),
        .IN_RESULT (IN_RESULT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_TAG   (OUT_TAG),
        .OUT_DATA  (OUT_DATA),
        .OUT_FLAGS (OUT_FLAGS),
        .LEVEL     (LEVEL)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        e_tag = '{5'd1, 5'd2, 5'd4, 5'd5};
        e_src = '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        e_res = '{32'hBF800000, 32'h00000000, 32'hCF000000, 32'h4F000000};
        e_flg = '{3'b010, 3'b001, 3'b010, 3'b100};

        nRST      = 1'b0;
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        IN_TAG    = '0;
        IN_SRC    = '0;
        IN_RESULT = '0;
        OUT_READY = 1'b0;

        step();
        chk("rst_level", LEVEL, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_data", OUT_DATA, 0);
        chk("rst_out_tag", OUT_TAG, 0);
        chk("rst_out_flags", OUT_FLAGS, 0);

        nRST = 1'b1;
        step();
        chk("ready_after_rst", IN_READY, 1);

        // Case 1: inexact positive result
        IN_VALID  = 1'b1;
        IN_TAG    = 5'd3;
        IN_SRC    = 32'h01000001;
        IN_RESULT = 32'h4B800000;
        step();
        IN_VALID = 1'b0;
        chk("c1_valid", OUT_VALID, 1);
        chk("c1_data", OUT_DATA, 32'h4B800000);
        chk("c1_flags", OUT_FLAGS, 3'b100);
        chk("c1_tag", OUT_TAG, 3);
        chk("c1_level", LEVEL, 1);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("c1_pop_level", LEVEL, 0);
        chk("c1_pop_valid", OUT_VALID, 0);

        // Cases 2-4: fill with four, fifth is refused
        for (int i = 0; i < 5; i++) begin
            IN_VALID  = 1'b1;
            IN_TAG    = (i < 4) ? e_tag[i] : 5'd9;
            IN_SRC    = (i < 4) ? e_src[i] : 32'd9;
            IN_RESULT = (i < 4) ? e_res[i] : 32'd9;
            step();
        end
        chk("full_level", LEVEL, 4);
        chk("full_in_ready", IN_READY, 0);
        chk("full_head_tag", OUT_TAG, 1);

        // Pop at full with a push offered: the push must be ignored
        IN_TAG    = 5'd9;
        OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("full_pop_level", LEVEL, 3);
        chk("full_pop_ready", IN_READY, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("drain_tag%0d", i), OUT_TAG, e_tag[i]);
            chk($sformatf("drain_data%0d", i), OUT_DATA, e_res[i]);
            chk($sformatf("drain_flags%0d", i), OUT_FLAGS, e_flg[i]);
            step();
        end
        OUT_READY = 1'b0;
        chk("drain_level", LEVEL, 0);
        chk("drain_valid", OUT_VALID, 0);

        // First entry's flags seen via a separate push/pop
        IN_VALID  = 1'b1;
        IN_TAG    = e_tag[0];
        IN_SRC    = e_src[0];
        IN_RESULT = e_res[0];
        step();
        IN_VALID = 1'b0;
        chk("neg1_flags", OUT_FLAGS, e_flg[0]);
        chk("neg1_data", OUT_DATA, e_res[0]);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("neg1_level", LEVEL, 0);

        // Case 5: steady push+pop at level 2
        for (int i = 0; i < 2; i++) begin
            IN_VALID  = 1'b1;
            IN_TAG    = 5'(10 + i);
            IN_SRC    = 32'(10 + i);
            IN_RESULT = 32'(10 + i);
            step();
        end
        chk("pp_pre_level", LEVEL, 2);
        OUT_READY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            IN_TAG    = 5'(12 + k);
            IN_SRC    = 32'(12 + k);
            IN_RESULT = 32'(12 + k);
            chk($sformatf("pp_head%0d", k), OUT_TAG, 10 + k);
            chk($sformatf("pp_data%0d", k), OUT_DATA, 10 + k);
            step();
            chk($sformatf("pp_level%0d", k), LEVEL, 2);
        end
        chk("pp_flags", OUT_FLAGS, 3'b000);

        // Case 6a: async reset at level 3
        OUT_READY = 1'b0;
        IN_TAG    = 5'd30;
        step();
        IN_VALID = 1'b0;
        chk("pre_rst_level", LEVEL, 3);
        #2;
        nRST = 1'b0;
        #1;
        chk("async_level", LEVEL, 0);
        chk("async_valid", OUT_VALID, 0);
        chk("async_ready", IN_READY, 0);
        step();
        nRST = 1'b1;
        step();
        chk("rerst_ready", IN_READY, 1);

        // Case 6b: flush at level 2 with push and pop offered
        IN_VALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            IN_TAG = 5'(20 + i);
            step();
        end
        chk("pre_flush_level", LEVEL, 2);
        FLUSH     = 1'b1;
        OUT_READY = 1'b1;
        IN_TAG    = 5'd22;
        step();
        FLUSH     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        chk("flush_level", LEVEL, 0);
        chk("flush_valid", OUT_VALID, 0);
        chk("flush_ready", IN_READY, 1);

        IN_VALID  = 1'b1;
        IN_TAG    = 5'd7;
        IN_SRC    = 32'h00000000;
        IN_RESULT = 32'h0000ABCD;
        step();
        IN_VALID = 1'b0;
        chk("post_flush_tag", OUT_TAG, 7);
        chk("post_flush_data", OUT_DATA, 32'h0000ABCD);
        chk("post_flush_level", LEVEL, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
